// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : 8N1 UART transmitter fed by a small byte FIFO (valid/ready in).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = CLK_FREQ / BAUD_RATE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_BW     = $clog2(DIV);
    localparam int c_DIV_M1 = DIV - 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_DIV_M1[c_BW-1:0];
    localparam logic [c_AW:0]   c_FULL      = FIFO_DEPTH[c_AW:0];
    localparam logic [3:0]      c_STOP_IDX  = 4'd9;
    localparam logic [0:0]      c_IDLE      = 1'b0;
    localparam logic [0:0]      c_SEND      = 1'b1;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_level;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [9:0]      r_shift;
    logic [c_BW-1:0] r_baud;
    logic [3:0]      r_bitcnt;
    logic            r_done;
    logic            w_push;
    logic            w_pop;
    logic            w_frame_end;
    logic            w_nonempty;
    logic            w_baud_last;

    assign w_nonempty  = (r_level != '0);
    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign tx_ready    = (r_level != c_FULL);
    assign w_push      = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_SEND;
                end
            end
            c_SEND: begin
                if (w_baud_last && (r_bitcnt == c_STOP_IDX)) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Storage carries no reset; only the pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (c_AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (c_AW+1)'(1);
            end
        end
    end

    // The line is bit 0 of the shift register; ones shift in behind the stop
    // bit, so the register naturally rests at all-ones (idle line) in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift  <= '1;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_pop) begin
                r_shift  <= {1'b1, r_mem[r_rptr], 1'b0};
                r_baud   <= '0;
                r_bitcnt <= '0;
            end else if (r_state == c_SEND) begin
                if (w_baud_last) begin
                    r_baud <= '0;
                    if (w_frame_end) begin
                        r_shift <= '1;
                    end else begin
                        r_shift  <= {1'b1, r_shift[9:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end else begin
                    r_baud <= r_baud + c_BW'(1);
                end
            end
        end
    end

    assign TxD   = r_shift[0];
    assign done  = r_done;
    assign level = r_level;
    assign busy  = (r_state == c_SEND) || w_nonempty;

endmodule
`default_nettype wire
